count_param: RTL and testbench

Parametrised loadable up/down counter, the next generation of the fixed 5-bit-load/6-bit-output `count` block. It adds configurable width and modulus, runtime direction control, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is used as a general event/timer counter in datapath and control logic, driven directly by a local enable strobe.

---
 rtl/count_param.sv | 125 ++++++++++++
 tb/tb_count_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/count_param.sv
// count_param: parametrised loadable up/down counter with modulus, wrap or
// saturate limit mode, one-cycle terminal-count pulse and sticky overflow flag.
// Optional enable prescaler is built only when COUNT_PRESCALER_EN is defined.
module count_param #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned MODULUS  = 64,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cntin,
  input  logic             load,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cntout,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned      WP1   = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_C = WP1'(MODULUS);

  // Elaboration-time parameter legality check
  if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH) ||
      PRESCALE < 2 || PRESCALE > 256) begin : g_param_err
    $error("count_param: illegal parameter combination");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic             set_c;

`ifdef COUNT_PRESCALER_EN
  localparam int unsigned   PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Prescaler: advance on enable, tick and restart at PRESCALE-1, clear on load
  always_comb begin
    pre_d  = pre_q;
    step_c = 1'b0;
    if (load) begin
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == PMAX) begin
        pre_d  = '0;
        step_c = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Prescaler state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end
`else
  // Without the prescaler every enabled cycle is a step
  assign step_c = enable;
`endif

  // Next-state: load beats step beats hold; limit events raise the overflow set
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    set_c = 1'b0;
    if (load) begin
      if ({1'b0, cntin} < MOD_C) begin
        cnt_d = cntin;
      end else begin
        cnt_d = MAX_C;
        set_c = 1'b1;
      end
    end else if (step_c) begin
      if (up_dn) begin
        if (cnt_q == MAX_C) begin
          set_c = 1'b1;
          if (!sat) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          set_c = 1'b1;
          if (!sat) begin
            cnt_d = MAX_C;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    ovf_d = set_c | (ovf_q & ~clr_ovf);
  end

  // Output state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cntout = cnt_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_count_param.sv
// Self-checking bench for count_param (WIDTH=6, MODULUS=40) against a
// behavioural model computed with plain integer arithmetic.
module tb_count_param;

  localparam int unsigned WIDTH    = 6;
  localparam int unsigned MODULUS  = 40;
  localparam int unsigned PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] cntin;
  logic             load, enable, up_dn, sat, clr_ovf;
  logic [WIDTH-1:0] cntout;
  logic             tc, ovf;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_cnt = 0;
  int m_pre = 0;
  bit m_tc  = 0;
  bit m_ovf = 0;

  count_param #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .cntin(cntin), .load(load), .enable(enable),
    .up_dn(up_dn), .sat(sat), .clr_ovf(clr_ovf),
    .cntout(cntout), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outputs follow from the counting rules on integers
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else begin
      bit set_ev, do_step;
      set_ev  = 0;
      do_step = 0;
      m_tc    = 0;
      if (load) begin
        m_pre = 0;
        if (int'(cntin) < MODULUS) m_cnt = int'(cntin);
        else begin m_cnt = MODULUS - 1; set_ev = 1; end
      end else if (enable) begin
`ifdef COUNT_PRESCALER_EN
        m_pre = m_pre + 1;
        if (m_pre == PRESCALE) begin m_pre = 0; do_step = 1; end
`else
        do_step = 1;
`endif
      end
      if (do_step) begin
        int nxt;
        nxt = up_dn ? m_cnt + 1 : m_cnt - 1;
        if (nxt < 0 || nxt >= MODULUS) begin
          set_ev = 1;
          if (!sat) begin
            m_cnt = (nxt + MODULUS) % MODULUS;
            m_tc  = 1;
          end
        end else begin
          m_cnt = nxt;
        end
      end
      if (set_ev)       m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Compare DUT to model every cycle, away from the active edge
  always @(negedge clk) begin
    check("cntout", int'(cntout), m_cnt);
    check("tc", int'(tc), int'(m_tc));
    check("ovf", int'(ovf), int'(m_ovf));
  end

  // Apply one cycle of inputs, wait through the edge, return at edge+2
  task automatic tick(input bit ld, input int ci, input bit en, input bit up,
                      input bit st, input bit clr);
    load    = ld;
    cntin   = WIDTH'(ci);
    enable  = en;
    up_dn   = up;
    sat     = st;
    clr_ovf = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; cntin = '0; load = 0; enable = 1; up_dn = 1; sat = 0; clr_ovf = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cnt", int'(cntout), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    tick(0, 0, 1, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);

`ifndef COUNT_PRESCALER_EN
    // Load then count up
    tick(1, 21, 1, 1, 0, 0);
    check("load21", int'(cntout), 21);
    check("load21_tc", int'(tc), 0);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 1, 1, 0, 0);
      check("up_after_load", int'(cntout), 21 + i);
    end
    // Out-of-range load clamps and flags overflow
    tick(1, 50, 0, 1, 0, 0);
    check("load50_cnt", int'(cntout), 39);
    check("load50_ovf", int'(ovf), 1);
    tick(0, 0, 0, 1, 0, 1);
    check("clr_ovf", int'(ovf), 0);

    // Up wrap
    tick(1, 38, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    check("wrap_39", int'(cntout), 39);
    check("wrap_39_tc", int'(tc), 0);
    tick(0, 0, 1, 1, 0, 0);
    check("wrap_0", int'(cntout), 0);
    check("wrap_0_tc", int'(tc), 1);
    check("wrap_0_ovf", int'(ovf), 1);
    tick(0, 0, 1, 1, 0, 0);
    check("wrap_1", int'(cntout), 1);
    check("wrap_1_tc", int'(tc), 0);
    tick(0, 0, 0, 1, 0, 1);
    check("wrap_clr", int'(ovf), 0);

    // Down saturate
    tick(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 1, 0);
      check("dsat_cnt", int'(cntout), 0);
      check("dsat_tc", int'(tc), 0);
    end
    check("dsat_ovf", int'(ovf), 1);
    tick(0, 0, 1, 0, 1, 1);
    check("set_beats_clr", int'(ovf), 1);
    tick(0, 0, 0, 0, 1, 1);
    check("clr_after", int'(ovf), 0);

    // Down wrap from 0
    tick(0, 0, 1, 0, 0, 0);
    check("dwrap_cnt", int'(cntout), 39);
    check("dwrap_tc", int'(tc), 1);

    // Asynchronous reset mid-count
    tick(1, 16, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    check("pre_arst", int'(cntout), 17);
    rst = 1'b0;
    #1;
    check("arst_cnt", int'(cntout), 0);
    check("arst_ovf", int'(ovf), 0);
    #1;
    rst = 1'b1;
`else
    // Prescaled stepping from 0
    tick(1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      tick(0, 0, 1, 1, 0, 0);
      check("presc_cnt", int'(cntout), i / 4);
    end
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 1, 1, 0, 0);
      check("presc_gap", int'(cntout), (i == 4) ? 4 : 3);
    end
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit ld, en, clr, up, st;
      int ci;
      ld  = ($urandom_range(0, 15) == 0);
      ci  = $urandom_range(0, 63);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      up  = (n / 200) % 2 == 0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      tick(ld, ci, en, up, st, clr);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
